// File: rtl/if_id_stage_pkg.sv
// Shared encodings and helpers for the IF stage and IF/ID pipeline register.
// Covers PC-source codes, the stall watchdog states and the NOP word.
package if_id_stage_pkg;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_J   = 2'b10;
    localparam logic [1:0] PCSRC_JR  = 2'b11;

    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        StRun,
        StHold,
        StErr
    } wd_state_e;

    // Saturating increment for the performance counters.
    function automatic logic [31:0] sat_inc(input logic [31:0] val);
        return (val == 32'hFFFF_FFFF) ? val : val + 32'd1;
    endfunction

endpackage

// File: rtl/if_id_stage_stall_watchdog.sv
// Watchdog over consecutive effective-stall cycles.
// Raises a sticky error flag once the run length reaches MAX_STALL.
module if_id_stage_stall_watchdog
    import if_id_stage_pkg::*;
#(
    parameter int unsigned MAX_STALL = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic stall_eff,
    output logic stall_err
);

    localparam int unsigned CntW =
        ($clog2(MAX_STALL + 1) > 3) ? $clog2(MAX_STALL + 1) : 3;
    localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_STALL);

    wd_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
    logic            err_q, err_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StRun;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cnt_inc = cnt_q + CntW'(1);
        unique case (state_q)
            StRun: begin
                if (stall_eff) begin
                    state_d = StHold;
                    cnt_d   = CntW'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            StHold: begin
                if (stall_eff) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == MaxCnt) begin
                        state_d = StErr;
                    end
                end else begin
                    state_d = StRun;
                    cnt_d   = '0;
                end
            end
            StErr: begin
                state_d = StErr;
            end
            default: begin
                state_d = StRun;
                cnt_d   = '0;
            end
        endcase
    end

    // Flag is flopped from the next-state decode so it tracks state_q == StErr exactly.
    always_comb begin
        err_d = (state_d == StErr);
    end

    assign stall_err = err_q;

endmodule

// File: rtl/if_id_stage.sv
// Instruction-fetch PC and IF/ID pipeline register with stall/redirect control,
// stall/flush performance counters and a stall watchdog.
module if_id_stage
    import if_id_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MAX_STALL = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic [1:0]  ID_PCSrc,
    input  logic        ID_BranchTaken,
    input  logic [31:0] ID_BranchTarget,
    input  logic [31:0] ID_JumpTarget,
    input  logic [31:0] ID_JrTarget,
    input  logic [31:0] IF_Instruction,
    output logic [31:0] IF_PC,
    output logic [31:0] ID_Instruction,
    output logic [31:0] ID_PC4,
    output logic        ID_Valid,
    output logic        ID_EX_Flush,
    output logic [31:0] Stall_Count,
    output logic [31:0] Flush_Count,
    output logic        Stall_Err
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic [31:0] stall_cnt_q, flush_cnt_q;

    logic [31:0] pc_plus4;
    logic [31:0] target;
    logic        stall_eff;
    logic        take;
    logic        redirect;

    // A stall is only meaningful when IF/ID holds a live instruction.
    always_comb begin
        pc_plus4  = pc_q + 32'd4;
        stall_eff = Stall & valid_q;
        take      = ((ID_PCSrc == PCSRC_BR) & ID_BranchTaken) | ID_PCSrc[1];
        redirect  = valid_q & ~stall_eff & take;
    end

    always_comb begin
        unique case (ID_PCSrc)
            PCSRC_SEQ: target = pc_plus4;
            PCSRC_BR:  target = ID_BranchTarget;
            PCSRC_J:   target = ID_JumpTarget;
            PCSRC_JR:  target = ID_JrTarget;
            default:   target = pc_plus4;
        endcase
    end

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (stall_eff) begin
            pc_d = pc_q;
        end else if (redirect) begin
            // The word fetched this cycle is wrong-path; drop it.
            pc_d    = target;
            instr_d = NOP;
            pc4_d   = 32'h0;
            valid_d = 1'b0;
        end else begin
            pc_d    = pc_plus4;
            instr_d = IF_Instruction;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= 32'h0;
            flush_cnt_q <= 32'h0;
        end else begin
            if (stall_eff) begin
                stall_cnt_q <= sat_inc(stall_cnt_q);
            end
            if (redirect) begin
                flush_cnt_q <= sat_inc(flush_cnt_q);
            end
        end
    end

    if_id_stage_stall_watchdog #(
        .MAX_STALL(MAX_STALL)
    ) u_stall_watchdog (
        .clk      (clk),
        .reset    (reset),
        .stall_eff(stall_eff),
        .stall_err(Stall_Err)
    );

    assign IF_PC          = pc_q;
    assign ID_Instruction = instr_q;
    assign ID_PC4         = pc4_q;
    assign ID_Valid       = valid_q;
    assign ID_EX_Flush    = stall_eff;
    assign Stall_Count    = stall_cnt_q;
    assign Flush_Count    = flush_cnt_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed table-driven bench for if_id_stage, plus hand sequences for async
// reset mid-stall and PC wrap from the top of the address space.
module tb_if_id_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic [1:0]  pcsrc;
    logic        taken;
    logic [31:0] br_tgt, j_tgt, jr_tgt, if_instr;

    logic [31:0] pc, id_instr, id_pc4, sc, fc;
    logic        id_valid, flush, err;
    logic [31:0] pc2, id_instr2, id_pc42, sc2, fc2;
    logic        id_valid2, flush2, err2;

    int checks = 0;
    int errors = 0;

    if_id_stage #(
        .RESET_PC (32'h0000_0000),
        .MAX_STALL(4)
    ) dut (
        .clk            (clk),
        .reset          (rst_n),
        .Stall          (stall),
        .ID_PCSrc       (pcsrc),
        .ID_BranchTaken (taken),
        .ID_BranchTarget(br_tgt),
        .ID_JumpTarget  (j_tgt),
        .ID_JrTarget    (jr_tgt),
        .IF_Instruction (if_instr),
        .IF_PC          (pc),
        .ID_Instruction (id_instr),
        .ID_PC4         (id_pc4),
        .ID_Valid       (id_valid),
        .ID_EX_Flush    (flush),
        .Stall_Count    (sc),
        .Flush_Count    (fc),
        .Stall_Err      (err)
    );

    if_id_stage #(
        .RESET_PC (32'hFFFF_FFFC),
        .MAX_STALL(4)
    ) dut_wrap (
        .clk            (clk),
        .reset          (rst_n),
        .Stall          (stall),
        .ID_PCSrc       (pcsrc),
        .ID_BranchTaken (taken),
        .ID_BranchTarget(br_tgt),
        .ID_JumpTarget  (j_tgt),
        .ID_JrTarget    (jr_tgt),
        .IF_Instruction (if_instr),
        .IF_PC          (pc2),
        .ID_Instruction (id_instr2),
        .ID_PC4         (id_pc42),
        .ID_Valid       (id_valid2),
        .ID_EX_Flush    (flush2),
        .Stall_Count    (sc2),
        .Flush_Count    (fc2),
        .Stall_Err      (err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic [1:0]  src;
        logic        taken;
        logic [31:0] tgt;
        logic [31:0] instr;
        logic        e_flush;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic        e_valid;
        logic [31:0] e_sc;
        logic [31:0] e_fc;
        logic        e_err;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic [1:0] src, input logic tk,
                                input logic [31:0] tgt, input logic [31:0] ins,
                                input logic ef, input logic [31:0] epc,
                                input logic [31:0] eins, input logic [31:0] epc4,
                                input logic ev, input logic [31:0] esc,
                                input logic [31:0] efc, input logic eerr);
        vec_t v;
        v.stall = s; v.src = src; v.taken = tk; v.tgt = tgt; v.instr = ins;
        v.e_flush = ef; v.e_pc = epc; v.e_instr = eins; v.e_pc4 = epc4;
        v.e_valid = ev; v.e_sc = esc; v.e_fc = efc; v.e_err = eerr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Only the selected target carries the real value; the others hold decoys.
    task automatic drive(input logic s, input logic [1:0] src, input logic tk,
                         input logic [31:0] tgt, input logic [31:0] ins);
        stall    = s;
        pcsrc    = src;
        taken    = tk;
        br_tgt   = (src == 2'b01) ? tgt : 32'hBAD0_0010;
        j_tgt    = (src == 2'b10) ? tgt : 32'hBAD0_0020;
        jr_tgt   = (src == 2'b11) ? tgt : 32'hBAD0_0030;
        if_instr = ins;
    endtask

    vec_t vecs[19];

    initial begin
        vecs[0]  = mk(0, 2'b00, 0, 32'h0,   32'h1111_0000, 0, 32'h4,   32'h1111_0000, 32'h4,   1, 0, 0, 0);
        vecs[1]  = mk(0, 2'b00, 0, 32'h0,   32'h1111_0004, 0, 32'h8,   32'h1111_0004, 32'h8,   1, 0, 0, 0);
        vecs[2]  = mk(0, 2'b00, 0, 32'h0,   32'h1111_0008, 0, 32'hC,   32'h1111_0008, 32'hC,   1, 0, 0, 0);
        vecs[3]  = mk(1, 2'b00, 0, 32'h0,   32'h1111_000C, 1, 32'hC,   32'h1111_0008, 32'hC,   1, 1, 0, 0);
        vecs[4]  = mk(1, 2'b00, 0, 32'h0,   32'h1111_000C, 1, 32'hC,   32'h1111_0008, 32'hC,   1, 2, 0, 0);
        vecs[5]  = mk(0, 2'b01, 1, 32'h40,  32'h1111_000C, 0, 32'h40,  32'h0,         32'h0,   0, 2, 1, 0);
        vecs[6]  = mk(1, 2'b01, 1, 32'h40,  32'h2222_0040, 0, 32'h44,  32'h2222_0040, 32'h44,  1, 2, 1, 0);
        vecs[7]  = mk(0, 2'b01, 0, 32'h80,  32'h2222_0044, 0, 32'h48,  32'h2222_0044, 32'h48,  1, 2, 1, 0);
        vecs[8]  = mk(1, 2'b10, 0, 32'h100, 32'h2222_0048, 1, 32'h48,  32'h2222_0044, 32'h48,  1, 3, 1, 0);
        vecs[9]  = mk(0, 2'b10, 0, 32'h100, 32'h2222_0048, 0, 32'h100, 32'h0,         32'h0,   0, 3, 2, 0);
        vecs[10] = mk(0, 2'b00, 0, 32'h0,   32'h3333_0100, 0, 32'h104, 32'h3333_0100, 32'h104, 1, 3, 2, 0);
        vecs[11] = mk(0, 2'b11, 0, 32'h200, 32'h3333_0104, 0, 32'h200, 32'h0,         32'h0,   0, 3, 3, 0);
        vecs[12] = mk(0, 2'b00, 0, 32'h0,   32'h4444_0200, 0, 32'h204, 32'h4444_0200, 32'h204, 1, 3, 3, 0);
        vecs[13] = mk(1, 2'b00, 0, 32'h0,   32'h4444_0204, 1, 32'h204, 32'h4444_0200, 32'h204, 1, 4, 3, 0);
        vecs[14] = mk(1, 2'b00, 0, 32'h0,   32'h4444_0204, 1, 32'h204, 32'h4444_0200, 32'h204, 1, 5, 3, 0);
        vecs[15] = mk(1, 2'b00, 0, 32'h0,   32'h4444_0204, 1, 32'h204, 32'h4444_0200, 32'h204, 1, 6, 3, 0);
        vecs[16] = mk(1, 2'b00, 0, 32'h0,   32'h4444_0204, 1, 32'h204, 32'h4444_0200, 32'h204, 1, 7, 3, 1);
        vecs[17] = mk(0, 2'b00, 0, 32'h0,   32'h4444_0204, 0, 32'h208, 32'h4444_0204, 32'h208, 1, 7, 3, 1);
        vecs[18] = mk(0, 2'b01, 1, 32'h300, 32'h4444_0208, 0, 32'h300, 32'h0,         32'h0,   0, 7, 4, 1);

        rst_n = 1'b0;
        drive(0, 2'b00, 0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset pc", pc, 32'h0);
        chk("reset valid", {31'b0, id_valid}, 32'h0);
        chk("reset flush", {31'b0, flush}, 32'h0);
        chk("reset wrap pc", pc2, 32'hFFFF_FFFC);
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].stall, vecs[i].src, vecs[i].taken, vecs[i].tgt, vecs[i].instr);
            #1;
            chk($sformatf("v%0d flush", i), {31'b0, flush}, {31'b0, vecs[i].e_flush});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d pc", i), pc, vecs[i].e_pc);
            chk($sformatf("v%0d instr", i), id_instr, vecs[i].e_instr);
            chk($sformatf("v%0d pc4", i), id_pc4, vecs[i].e_pc4);
            chk($sformatf("v%0d valid", i), {31'b0, id_valid}, {31'b0, vecs[i].e_valid});
            chk($sformatf("v%0d stall_cnt", i), sc, vecs[i].e_sc);
            chk($sformatf("v%0d flush_cnt", i), fc, vecs[i].e_fc);
            chk($sformatf("v%0d stall_err", i), {31'b0, err}, {31'b0, vecs[i].e_err});
        end

        // Asynchronous reset in the middle of an effective stall while in ERR.
        drive(0, 2'b00, 0, 32'h0, 32'h5555_0300);
        @(posedge clk);
        #1;
        chk("pre-reset pc", pc, 32'h304);
        drive(1, 2'b00, 0, 32'h0, 32'h5555_0304);
        #1;
        chk("pre-reset flush", {31'b0, flush}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("async pc", pc, 32'h0);
        chk("async instr", id_instr, 32'h0);
        chk("async pc4", id_pc4, 32'h0);
        chk("async valid", {31'b0, id_valid}, 32'h0);
        chk("async flush", {31'b0, flush}, 32'h0);
        chk("async stall_cnt", sc, 32'h0);
        chk("async flush_cnt", fc, 32'h0);
        chk("async stall_err", {31'b0, err}, 32'h0);
        @(posedge clk);
        #1;
        chk("held reset pc", pc, 32'h0);
        rst_n = 1'b1;

        // Stall with an empty IF/ID is ignored; wrap instance rolls over to 0.
        drive(1, 2'b00, 0, 32'h0, 32'h6666_0000);
        #1;
        chk("idle stall flush", {31'b0, flush}, 32'h0);
        chk("wrap idle flush", {31'b0, flush2}, 32'h0);
        @(posedge clk);
        #1;
        chk("first fetch pc", pc, 32'h4);
        chk("first fetch valid", {31'b0, id_valid}, 32'h1);
        chk("first fetch stall_cnt", sc, 32'h0);
        chk("wrap pc", pc2, 32'h0);
        chk("wrap pc4", id_pc42, 32'h0);
        chk("wrap instr", id_instr2, 32'h6666_0000);
        chk("wrap valid", {31'b0, id_valid2}, 32'h1);
        chk("wrap stall_cnt", sc2, 32'h0);
        chk("wrap flush_cnt", fc2, 32'h0);
        chk("wrap stall_err", {31'b0, err2}, 32'h0);
        drive(0, 2'b00, 0, 32'h0, 32'h6666_0004);
        @(posedge clk);
        #1;
        chk("wrap pc next", pc2, 32'h4);
        chk("wrap pc4 next", id_pc42, 32'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
